mips32_core: RTL and testbench
==============================

Name: mips32_core

Overview:
- Single-issue, five-stage pipelined 32-bit RISC processor (IF, ID, EX, MEM, WB) with a reduced MIPS-like instruction set.
- Uses one unified word-addressed instruction/data memory held inside the block.
- Memory is preloaded by the testbench through hierarchical access; the core runs from address 0 after reset until it executes HLT.
- Standalone top-level compute block for directed program tests.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the unified memory array `mem`; address = low log2(MEM_WORDS) bits.
- RESET_PC, 0, word address of the first fetch after reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc  output  32  current fetch address (word address).
- halted  output  1  high once HLT has retired; sticky until reset.
- taken_branch  output  1  pulses high for the cycle in which a taken branch redirects fetch.

Behaviour:
- Internal arrays `mem[0:MEM_WORDS-1]` (32b) and `regfile[0:31]` (32b) are hierarchically accessible for preload/inspection. mem is not reset.
- Reset (async, rst_n=0):
  - pc=RESET_PC, halted=0, taken_branch=0.
  - All pipeline registers hold bubbles (NOP).
  - regfile cleared to 0.
- Encoding: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0] sign-extended to 32b.
- R-type: rd <= rs OP rt.
  - ADD 000000; SUB 000001; AND 000010; OR 000011.
  - SLT 000100: signed compare, result 1/0.
  - MUL 000101: low 32 bits of the product.
- I-type:
  - LW 001000: rt <= mem[rs+imm].
  - SW 001001: mem[rs+imm] <= rt.
  - ADDI 001010; SUBI 001011; SLTI 001100 (signed): rt <= rs OP imm.
  - BNEQZ 001101; BEQZ 001110: test rs against zero.
  - HLT 111111.
  - Any other opcode executes as NOP.
- Arithmetic wraps modulo 2^32. Writes to r0 are discarded; r0 always reads 0.
- Fetch: IF reads mem[pc]; pc <= pc+1 each cycle unless redirected or halting.
- Register file is write-before-read: a WB write is visible to an ID read in the same cycle.
- Forwarding into EX operands (rs and rt, including SW store data and the branch operand):
  - from EX/MEM for ALU results;
  - from MEM/WB for ALU and load results.
  - No interlock: software must separate a load from its consumer by at least 1 instruction. ALU results may be consumed by the next instruction.
- Branches resolve in EX.
  - Target = branch_address + 1 + imm.
  - If taken: pc <= target at the end of that cycle, the two younger instructions (in IF/ID and in fetch) are squashed to bubbles, and taken_branch=1 for that cycle.
  - Not-taken branches cost nothing.
- SW writes mem in MEM. LW reads in MEM; the value is written back in WB.
- A squashed instruction never writes regfile or mem.
- HLT:
  - When HLT is decoded, fetch stops (pc holds) and younger instructions are squashed.
  - Older instructions complete.
  - When HLT reaches WB, halted<=1 and the pipeline freezes: no further regfile or mem writes.
  - Stays halted until reset.
- Reset mid-run: immediate abort. mem keeps any stores already committed; restart fetch at RESET_PC.
- Memory address: (rs+imm) truncated to the array index width; pc wraps likewise.

Test Plan:
- ALU/immediate:
  - Stimulus: ADDI r1,r0,10; ADDI r2,r0,20; ADD r3,r1,r2; SUB r4,r2,r1; SLT r5,r1,r2; SLTI r6,r1,-1; MUL r7,r1,r2; HLT.
  - Required: r3=30, r4=10, r5=1, r6=0, r7=200, halted=1.
- Forwarding:
  - Stimulus: back-to-back ADDI r1,r0,5; ADDI r2,r1,1; ADD r3,r2,r1.
  - Required: r2=6, r3=11 with no NOPs.
  - Stimulus: LW r4 from mem[120]=7, one NOP, ADD r5,r4,r4.
  - Required: r5=14.
- Branch squash:
  - Stimulus: BEQZ r0,+2 followed by ADDI r1,r0,1 and ADDI r2,r0,2, target ADDI r3,r0,3.
  - Required: r1=r2=0, r3=3, taken_branch pulses once.
  - Stimulus: same program using BNEQZ r0.
  - Required: not taken, r1=1, r2=2, r3=3.
- Bubble sort program (mem[99]=4, mem[100..103]=10,25,50,20; outer exit branch targeting HLT):
  - Required: mem[100..103]=10,20,25,50; halted=1.
- HLT freeze:
  - Stimulus: HLT followed by ADDI r1,r0,9 and SW r1,0(r0).
  - Required: r1=0, mem[0] unchanged, pc stable, halted stays 1 for 20+ cycles.
- Reset mid-run:
  - Stimulus: assert rst_n low asynchronously during a loop.
  - Required: pc=0, halted=0, regfile=0 immediately; reruns correctly after release.

Source files
------------

// File: rtl/mips32_core.sv
// mips32_core: five-stage (IF/ID/EX/MEM/WB) pipelined 32-bit MIPS-like core
// with a unified word-addressed instruction/data memory.
//   clk          - single clock, rising edge
//   rst_n        - asynchronous active-low reset
//   pc           - current fetch address (word address, zero-extended)
//   halted       - high once HLT has retired, sticky until reset
//   taken_branch - high during the cycle a taken branch redirects fetch
module mips32_core #(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  output logic        halted,
  output logic        taken_branch
);
  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  logic [31:0] mem     [0:MEM_WORDS-1];
  logic [31:0] regfile [0:31];

  logic [AW-1:0] pc_q, pc_d;
  logic          halted_q, halted_d, halt_pend_q, halt_pend_d;
  logic          ifid_v_q, ifid_v_d;
  logic [31:0]   ifid_ir_q, ifid_ir_d;
  logic [AW-1:0] ifid_pc_q, ifid_pc_d;
  logic          idex_v_q, idex_v_d;
  logic [31:0]   idex_ir_q, idex_ir_d, idex_a_q, idex_a_d, idex_b_q, idex_b_d;
  logic [AW-1:0] idex_pc_q, idex_pc_d;
  logic          exmem_v_q, exmem_v_d, exmem_wr_q, exmem_wr_d;
  logic [5:0]    exmem_op_q, exmem_op_d;
  logic [4:0]    exmem_dst_q, exmem_dst_d;
  logic [31:0]   exmem_alu_q, exmem_alu_d, exmem_sd_q, exmem_sd_d;
  logic          memwb_wr_q, memwb_wr_d, memwb_hlt_q, memwb_hlt_d;
  logic [4:0]    memwb_dst_q, memwb_dst_d;
  logic [31:0]   memwb_val_q, memwb_val_d;

  logic [4:0]    id_rs, id_rt, ex_rs, ex_rt, ex_dst;
  logic [5:0]    ex_op;
  logic [31:0]   id_a, id_b, ex_a, ex_b, ex_imm, ex_alu, mem_rdata;
  logic          id_hlt, ex_wr, ex_taken;
  logic [AW-1:0] ex_target;

  assign pc           = 32'(pc_q);
  assign halted       = halted_q;
  assign taken_branch = ex_taken;

  // ID: register read with write-before-read bypass from WB
  assign id_rs  = ifid_ir_q[25:21];
  assign id_rt  = ifid_ir_q[20:16];
  assign id_hlt = ifid_v_q && (ifid_ir_q[31:26] == OP_HLT);

  always_comb begin
    id_a = regfile[id_rs];
    id_b = regfile[id_rt];
    if (memwb_wr_q && memwb_dst_q == id_rs) id_a = memwb_val_q;
    if (memwb_wr_q && memwb_dst_q == id_rt) id_b = memwb_val_q;
  end

  // EX: operand forwarding (EX/MEM carries no load data yet), ALU, branch
  assign ex_op  = idex_ir_q[31:26];
  assign ex_rs  = idex_ir_q[25:21];
  assign ex_rt  = idex_ir_q[20:16];
  assign ex_imm = {{16{idex_ir_q[15]}}, idex_ir_q[15:0]};

  always_comb begin
    ex_a = idex_a_q;
    if (exmem_wr_q && exmem_op_q != OP_LW && exmem_dst_q == ex_rs) ex_a = exmem_alu_q;
    else if (memwb_wr_q && memwb_dst_q == ex_rs)                   ex_a = memwb_val_q;
    ex_b = idex_b_q;
    if (exmem_wr_q && exmem_op_q != OP_LW && exmem_dst_q == ex_rt) ex_b = exmem_alu_q;
    else if (memwb_wr_q && memwb_dst_q == ex_rt)                   ex_b = memwb_val_q;
  end

  always_comb begin
    ex_alu = '0;
    ex_wr  = 1'b0;
    ex_dst = (ex_op <= OP_MUL) ? idex_ir_q[15:11] : ex_rt;
    case (ex_op)
      OP_ADD:  begin ex_alu = ex_a + ex_b;                             ex_wr = 1'b1; end
      OP_SUB:  begin ex_alu = ex_a - ex_b;                             ex_wr = 1'b1; end
      OP_AND:  begin ex_alu = ex_a & ex_b;                             ex_wr = 1'b1; end
      OP_OR:   begin ex_alu = ex_a | ex_b;                             ex_wr = 1'b1; end
      OP_SLT:  begin ex_alu = {31'b0, $signed(ex_a) < $signed(ex_b)};  ex_wr = 1'b1; end
      OP_MUL:  begin ex_alu = ex_a * ex_b;                             ex_wr = 1'b1; end
      OP_LW:   begin ex_alu = ex_a + ex_imm;                           ex_wr = 1'b1; end
      OP_SW:   ex_alu = ex_a + ex_imm;
      OP_ADDI: begin ex_alu = ex_a + ex_imm;                           ex_wr = 1'b1; end
      OP_SUBI: begin ex_alu = ex_a - ex_imm;                           ex_wr = 1'b1; end
      OP_SLTI: begin ex_alu = {31'b0, $signed(ex_a) < $signed(ex_imm)}; ex_wr = 1'b1; end
      default: ;
    endcase
    ex_wr = ex_wr && idex_v_q && (ex_dst != 5'd0);
  end

  assign ex_taken  = idex_v_q && (((ex_op == OP_BEQZ) && (ex_a == '0)) ||
                                  ((ex_op == OP_BNEQZ) && (ex_a != '0)));
  assign ex_target = idex_pc_q + AW'(1) + ex_imm[AW-1:0];

  assign mem_rdata = mem[exmem_alu_q[AW-1:0]];

  always_comb begin
    // IF: a taken branch outranks a decoded HLT, since that HLT is younger
    pc_d        = pc_q + AW'(1);
    ifid_v_d    = 1'b1;
    ifid_ir_d   = mem[pc_q];
    ifid_pc_d   = pc_q;
    halt_pend_d = halt_pend_q || (id_hlt && !ex_taken);
    if (ex_taken) begin
      pc_d     = ex_target;
      ifid_v_d = 1'b0;
    end else if (halt_pend_q || id_hlt) begin
      pc_d     = pc_q;
      ifid_v_d = 1'b0;
    end
    idex_v_d    = ifid_v_q && !ex_taken;
    idex_ir_d   = ifid_ir_q;
    idex_pc_d   = ifid_pc_q;
    idex_a_d    = id_a;
    idex_b_d    = id_b;
    exmem_v_d   = idex_v_q;
    exmem_op_d  = ex_op;
    exmem_wr_d  = ex_wr;
    exmem_dst_d = ex_dst;
    exmem_alu_d = ex_alu;
    exmem_sd_d  = ex_b;
    memwb_wr_d  = exmem_wr_q;
    memwb_dst_d = exmem_dst_q;
    memwb_val_d = (exmem_op_q == OP_LW) ? mem_rdata : exmem_alu_q;
    memwb_hlt_d = exmem_v_q && (exmem_op_q == OP_HLT);
    halted_d    = halted_q || memwb_hlt_q;
  end

  // Only the HLT itself is live when it reaches WB, so gating every update
  // on halted_q is enough to freeze the core from the next cycle on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= AW'(RESET_PC);
      halted_q    <= 1'b0;
      halt_pend_q <= 1'b0;
      ifid_v_q    <= 1'b0;
      ifid_ir_q   <= '0;
      ifid_pc_q   <= '0;
      idex_v_q    <= 1'b0;
      idex_ir_q   <= '0;
      idex_pc_q   <= '0;
      idex_a_q    <= '0;
      idex_b_q    <= '0;
      exmem_v_q   <= 1'b0;
      exmem_op_q  <= '0;
      exmem_wr_q  <= 1'b0;
      exmem_dst_q <= '0;
      exmem_alu_q <= '0;
      exmem_sd_q  <= '0;
      memwb_wr_q  <= 1'b0;
      memwb_dst_q <= '0;
      memwb_val_q <= '0;
      memwb_hlt_q <= 1'b0;
      for (int unsigned i = 0; i < 32; i++) regfile[i] <= '0;
    end else if (!halted_q) begin
      pc_q        <= pc_d;
      halted_q    <= halted_d;
      halt_pend_q <= halt_pend_d;
      ifid_v_q    <= ifid_v_d;
      ifid_ir_q   <= ifid_ir_d;
      ifid_pc_q   <= ifid_pc_d;
      idex_v_q    <= idex_v_d;
      idex_ir_q   <= idex_ir_d;
      idex_pc_q   <= idex_pc_d;
      idex_a_q    <= idex_a_d;
      idex_b_q    <= idex_b_d;
      exmem_v_q   <= exmem_v_d;
      exmem_op_q  <= exmem_op_d;
      exmem_wr_q  <= exmem_wr_d;
      exmem_dst_q <= exmem_dst_d;
      exmem_alu_q <= exmem_alu_d;
      exmem_sd_q  <= exmem_sd_d;
      memwb_wr_q  <= memwb_wr_d;
      memwb_dst_q <= memwb_dst_d;
      memwb_val_q <= memwb_val_d;
      memwb_hlt_q <= memwb_hlt_d;
      if (memwb_wr_q) regfile[memwb_dst_q] <= memwb_val_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!halted_q && exmem_v_q && exmem_op_q == OP_SW)
      mem[exmem_alu_q[AW-1:0]] <= exmem_sd_q;
  end
endmodule

// File: tb/tb_mips32_core.sv
module tb_mips32_core;
  localparam int unsigned MW = 1024;
  localparam logic [5:0] ADD = 6'd0, SUB = 6'd1, AND_ = 6'd2, OR_ = 6'd3, SLT = 6'd4, MUL = 6'd5;
  localparam logic [5:0] LW = 6'd8, SW = 6'd9, ADDI = 6'd10, SUBI = 6'd11, SLTI = 6'd12;
  localparam logic [5:0] BNEQZ = 6'd13, BEQZ = 6'd14, NOP = 6'd16, HLT = 6'd63;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc;
  logic        halted, taken_branch;

  mips32_core #(.MEM_WORDS(MW), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .halted(halted), .taken_branch(taken_branch)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0, n_pass = 0;
  logic [31:0] img     [0:MW-1];
  logic [31:0] exp_mem [0:15][0:MW-1];
  logic [31:0] exp_reg [0:15][0:31];
  logic [31:0] exp_br  [0:15];
  logic [31:0] exp_pc  [0:15];
  int unsigned sb_q[$];
  bit          done;

  function automatic logic [31:0] rr(input logic [5:0] op, input int unsigned rd, rs, rt);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'b0};
  endfunction

  function automatic logic [31:0] ii(input logic [5:0] op, input int unsigned rt, rs, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic clear_img();
    for (int unsigned i = 0; i < MW; i++) img[i] = '0;
  endtask

  // Instruction-set interpreter: executes the image one instruction at a time
  task automatic model(input int unsigned id);
    logic [9:0]  p;
    logic [31:0] ir, a, b, imm, v;
    logic [5:0]  op;
    int unsigned dst, steps;
    bit          stop, tk;
    for (int unsigned i = 0; i < MW; i++) exp_mem[id][i] = img[i];
    for (int unsigned i = 0; i < 32; i++) exp_reg[id][i] = '0;
    exp_br[id] = 0; exp_pc[id] = '0;
    p = '0; stop = 0; steps = 0;
    while (!stop && steps < 20000) begin
      ir  = exp_mem[id][p];
      op  = ir[31:26];
      a   = exp_reg[id][ir[25:21]];
      b   = exp_reg[id][ir[20:16]];
      imm = {{16{ir[15]}}, ir[15:0]};
      dst = 0; v = '0; tk = 0;
      case (op)
        ADD:   begin v = a + b; dst = ir[15:11]; end
        SUB:   begin v = a - b; dst = ir[15:11]; end
        AND_:  begin v = a & b; dst = ir[15:11]; end
        OR_:   begin v = a | b; dst = ir[15:11]; end
        SLT:   begin v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; dst = ir[15:11]; end
        MUL:   begin v = a * b; dst = ir[15:11]; end
        LW:    begin v = exp_mem[id][10'(a + imm)]; dst = ir[20:16]; end
        SW:    exp_mem[id][10'(a + imm)] = b;
        ADDI:  begin v = a + imm; dst = ir[20:16]; end
        SUBI:  begin v = a - imm; dst = ir[20:16]; end
        SLTI:  begin v = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0; dst = ir[20:16]; end
        BEQZ:  tk = (a == 0);
        BNEQZ: tk = (a != 0);
        HLT:   begin stop = 1; exp_pc[id] = {22'b0, 10'(p + 10'd1)}; end
        default: ;
      endcase
      if (dst != 0) exp_reg[id][dst] = v;
      if (tk) exp_br[id] = exp_br[id] + 1;
      p = tk ? 10'(32'(p) + 1 + imm) : p + 10'd1;
      steps++;
    end
  endtask

  task automatic launch(input int unsigned id, input bit reload);
    rst_n = 1'b0;
    if (reload) for (int unsigned i = 0; i < MW; i++) dut.mem[i] <= img[i];
    model(id);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic score(input int unsigned id);
    done = 0;
    sb_q.push_back(id);
    for (int unsigned c = 0; c < 8000 && !done; c++) @(negedge clk);
    check($sformatf("t%0d_scoreboard_drain", id), {31'b0, done}, 32'd1);
  endtask

  // Monitor: on each halt, pop the expectation and compare architectural state
  initial begin : monitor
    int unsigned id, cyc, br, bad, bad_at;
    logic [31:0] hold_pc;
    bit stable;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        id = sb_q.pop_front(); cyc = 0; br = 0;
        while (!halted && cyc < 6000) begin
          if (taken_branch) br++;
          @(negedge clk);
          cyc++;
        end
        check($sformatf("t%0d_halted", id), {31'b0, halted}, 32'd1);
        check($sformatf("t%0d_halt_pc", id), pc, exp_pc[id]);
        hold_pc = pc; stable = 1;
        repeat (20) begin
          @(negedge clk);
          if (pc !== hold_pc || halted !== 1'b1 || taken_branch !== 1'b0) stable = 0;
        end
        check($sformatf("t%0d_freeze", id), {31'b0, stable}, 32'd1);
        check($sformatf("t%0d_taken_branches", id), br, exp_br[id]);
        for (int unsigned r = 0; r < 32; r++)
          check($sformatf("t%0d_r%0d", id, r), dut.regfile[r], exp_reg[id][r]);
        bad = 0; bad_at = 0;
        for (int unsigned i = 0; i < MW; i++)
          if (dut.mem[i] !== exp_mem[id][i]) begin
            if (bad == 0) bad_at = i;
            bad++;
          end
        check($sformatf("t%0d_mem_words_differing_first_at_%0d", id, bad_at), bad, 32'd0);
        done = 1;
      end
    end
  end

  task automatic gen_random();
    int unsigned n, k;
    clear_img();
    for (int unsigned i = 200; i < 216; i++) img[i] = $urandom;
    n = 0;
    while (n < 28) begin
      k = $urandom_range(0, 11);
      case (k)
        0, 1, 2, 3, 4, 5:
          img[n] = rr(6'(k), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        6:  img[n] = ii(6'($urandom_range(10, 12)), $urandom_range(0, 7), $urandom_range(0, 7),
                        int'($urandom_range(0, 65535)));
        7: begin
          img[n] = ii(LW, $urandom_range(0, 7), 0, 200 + int'($urandom_range(0, 15)));
          n++;
          img[n] = rr(NOP, 0, 0, 0);
        end
        8:  img[n] = ii(SW, $urandom_range(0, 7), 0, 200 + int'($urandom_range(0, 15)));
        9:  img[n] = ii(($urandom_range(0, 1) == 1) ? BEQZ : BNEQZ, 0, $urandom_range(0, 7),
                        (n < 24) ? int'($urandom_range(0, 3)) : 0);
        10: img[n] = {6'($urandom_range(16, 62)), 26'($urandom)};
        default: img[n] = ii(ADDI, $urandom_range(1, 7), 0, int'($urandom_range(0, 65535)));
      endcase
      n++;
    end
    img[n]     = ii(HLT, 0, 0, 0);
    img[n + 1] = ii(ADDI, 1, 0, 77);
    img[n + 2] = ii(SW, 1, 0, 201);
  endtask

  initial begin : driver
    int unsigned bad;
    #2 rst_n = 1'b0;
    #1;
    check("reset_pc", pc, 32'd0);
    check("reset_halted", {31'b0, halted}, 32'd0);
    check("reset_taken_branch", {31'b0, taken_branch}, 32'd0);

    // ALU / immediate
    clear_img();
    img[0] = ii(ADDI, 1, 0, 10);  img[1] = ii(ADDI, 2, 0, 20);
    img[2] = rr(ADD, 3, 1, 2);    img[3] = rr(SUB, 4, 2, 1);
    img[4] = rr(SLT, 5, 1, 2);    img[5] = ii(SLTI, 6, 1, -1);
    img[6] = rr(MUL, 7, 1, 2);    img[7] = ii(HLT, 0, 0, 0);
    launch(0, 1); score(0);

    // Forwarding, including load with one separating instruction
    clear_img();
    img[0] = ii(ADDI, 1, 0, 5);   img[1] = ii(ADDI, 2, 1, 1);
    img[2] = rr(ADD, 3, 2, 1);    img[3] = ii(LW, 4, 0, 120);
    img[4] = rr(NOP, 0, 0, 0);    img[5] = rr(ADD, 5, 4, 4);
    img[6] = ii(HLT, 0, 0, 0);    img[120] = 32'd7;
    launch(1, 1); score(1);

    // Branch squash: taken BEQZ, then the same shape with BNEQZ (not taken)
    for (int unsigned t = 2; t < 4; t++) begin
      clear_img();
      img[0] = ii((t == 2) ? BEQZ : BNEQZ, 0, 0, 2);
      img[1] = ii(ADDI, 1, 0, 1); img[2] = ii(ADDI, 2, 0, 2);
      img[3] = ii(ADDI, 3, 0, 3); img[4] = ii(HLT, 0, 0, 0);
      launch(t, 1); score(t);
    end

    // Bubble sort of mem[100..103], length in mem[99]
    clear_img();
    img[0]  = ii(LW, 1, 0, 99);   img[1]  = ii(ADDI, 10, 0, 0);
    img[2]  = ii(SUBI, 1, 1, 1);  img[3]  = ii(BEQZ, 0, 1, 14);
    img[4]  = ii(ADDI, 2, 0, 100); img[5] = rr(ADD, 3, 1, 0);
    img[6]  = ii(LW, 4, 2, 0);    img[7]  = ii(LW, 5, 2, 1);
    img[8]  = ii(ADDI, 10, 0, 0); img[9]  = rr(SLT, 6, 5, 4);
    img[10] = ii(BEQZ, 0, 6, 2);  img[11] = ii(SW, 5, 2, 0);
    img[12] = ii(SW, 4, 2, 1);    img[13] = ii(ADDI, 2, 2, 1);
    img[14] = ii(SUBI, 3, 3, 1);  img[15] = ii(BNEQZ, 0, 3, -10);
    img[16] = ii(SUBI, 1, 1, 1);  img[17] = ii(BEQZ, 0, 0, -15);
    img[18] = ii(HLT, 0, 0, 0);
    img[99] = 32'd4; img[100] = 32'd10; img[101] = 32'd25; img[102] = 32'd50; img[103] = 32'd20;
    launch(4, 1); score(4);

    // HLT freeze: younger ADDI/SW must never commit
    clear_img();
    img[0] = ii(HLT, 0, 0, 0); img[1] = ii(ADDI, 1, 0, 9); img[2] = ii(SW, 1, 0, 0);
    launch(5, 1); score(5);

    // Reset mid-run inside a store loop, then rerun without reloading memory
    clear_img();
    img[0] = ii(ADDI, 1, 0, 0);   img[1] = ii(ADDI, 1, 1, 1);
    img[2] = ii(SW, 1, 0, 200);   img[3] = ii(SUBI, 2, 1, 50);
    img[4] = ii(BNEQZ, 0, 2, -4); img[5] = ii(HLT, 0, 0, 0);
    launch(6, 1);
    repeat (40) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midreset_pc", pc, 32'd0);
    check("midreset_halted", {31'b0, halted}, 32'd0);
    check("midreset_taken_branch", {31'b0, taken_branch}, 32'd0);
    bad = 0;
    for (int unsigned r = 0; r < 32; r++) if (dut.regfile[r] !== 32'd0) bad++;
    check("midreset_nonzero_regs", bad, 32'd0);
    check("midreset_store_kept", {31'b0, dut.mem[200] != 32'd0}, 32'd1);
    launch(6, 0); score(6);

    // Randomized straight-line programs with forward branches
    for (int unsigned t = 7; t < 13; t++) begin
      gen_random();
      launch(t, 1); score(t);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
